// File: rtl/memory_access_unit_pkg.sv
// Shared definitions for the memory access unit: opcodes, FSM states,
// timeout limit, bus widths and the per-transaction context record.
package memory_access_unit_pkg;

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned REG_W  = 4;
    localparam int unsigned OPC_W  = 7;
    localparam int unsigned IMM_W  = 12;
    localparam int unsigned WAIT_W = 8;

    localparam logic [OPC_W-1:0] OPC_LDR = 7'b0100001;
    localparam logic [OPC_W-1:0] OPC_STR = 7'b0100000;

    // Number of REQ cycles without mem_ack before the access is abandoned.
    localparam int unsigned TIMEOUT_LIMIT = 255;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_DONE = 2'd2
    } mau_state_e;

    // Everything captured at accept time and held until the access retires.
    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
        logic [REG_W-1:0]  rd;
        logic [REG_W-1:0]  rn;
        logic [ADDR_W-1:0] offset_addr;
        logic              is_load;
        logic              base_wb;
    } mau_txn_t;

    function automatic logic is_mem_op(input logic [OPC_W-1:0] opc);
        return (opc == OPC_LDR) || (opc == OPC_STR);
    endfunction

endpackage

// File: rtl/memory_access_unit_if.sv
// Memory bus between the access unit (master) and the memory (slave).
//   mem_req/mem_we/mem_addr/mem_wdata : request, driven by the master
//   mem_ack/mem_rdata                 : completion and load data, driven by the slave
interface memory_access_unit_if;
    import memory_access_unit_pkg::*;

    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_ack;
    logic [DATA_W-1:0] mem_rdata;

    modport master (
        output mem_req, mem_we, mem_addr, mem_wdata,
        input  mem_ack, mem_rdata
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_wdata,
        output mem_ack, mem_rdata
    );

endinterface

// File: rtl/memory_access_unit_mem_addr_gen.sv
// mem_addr_gen: combinational address generation for LDR/STR.
//   rn_value_i, imm12_i, p_i, u_i, w_i : base value, offset, pre-index/add/writeback
//   offset_addr_c : base +/- zero-extended imm12 (mod 2^32)
//   access_addr_c : pre-indexed -> offset_addr, post-indexed -> base
//   base_wb_c     : base register writeback requested (post-index or W)
module mem_addr_gen
    import memory_access_unit_pkg::*;
(
    input  logic [ADDR_W-1:0] rn_value_i,
    input  logic [IMM_W-1:0]  imm12_i,
    input  logic              p_i,
    input  logic              u_i,
    input  logic              w_i,
    output logic [ADDR_W-1:0] offset_addr_c,
    output logic [ADDR_W-1:0] access_addr_c,
    output logic              base_wb_c
);

    logic [ADDR_W-1:0] imm_ext;

    assign imm_ext       = ADDR_W'(imm12_i);
    assign offset_addr_c = u_i ? (rn_value_i + imm_ext) : (rn_value_i - imm_ext);
    assign access_addr_c = p_i ? offset_addr_c : rn_value_i;
    // Post-indexed accesses always update the base.
    assign base_wb_c     = !p_i || w_i;

endmodule

// File: rtl/memory_access_unit.sv
// memory_access_unit: executes one LDR/STR at a time over the memory bus.
//   clk, rst_n            : clock, async active-low reset
//   instr_valid, cond_pass, opcode, rn, rd, rn_value, rd_value, imm12, P, U, W : decoded instruction
//   bus (master)          : memory request/ack bus
//   stall                 : hold upstream while the access is outstanding
//   wb_en/wb_rd/wb_data   : load result writeback pulse
//   base_wb_en/_rd/_data  : base register writeback pulse
//   mem_fault             : sticky timeout fault
// Build option: MEM_TIMEOUT_EN adds a REQ wait counter that abandons an
// unacknowledged access and raises mem_fault.
module memory_access_unit
    import memory_access_unit_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              instr_valid,
    input  logic              cond_pass,
    input  logic [OPC_W-1:0]  opcode,
    input  logic [REG_W-1:0]  rn,
    input  logic [REG_W-1:0]  rd,
    input  logic [ADDR_W-1:0] rn_value,
    input  logic [DATA_W-1:0] rd_value,
    input  logic [IMM_W-1:0]  imm12,
    input  logic              P,
    input  logic              U,
    input  logic              W,
    memory_access_unit_if.master bus,
    output logic              stall,
    output logic              wb_en,
    output logic [REG_W-1:0]  wb_rd,
    output logic [DATA_W-1:0] wb_data,
    output logic              base_wb_en,
    output logic [REG_W-1:0]  base_wb_rd,
    output logic [ADDR_W-1:0] base_wb_data,
    output logic              mem_fault
);

    mau_state_e        state_q;
    mau_txn_t          txn_q, txn_d;
    logic              mem_req_q, mem_we_q, stall_q;
    logic              wb_en_q, base_wb_en_q;
    logic [REG_W-1:0]  wb_rd_q, base_wb_rd_q;
    logic [DATA_W-1:0] wb_data_q;
    logic [ADDR_W-1:0] base_wb_data_q;

    logic [ADDR_W-1:0] offset_addr_c, access_addr_c;
    logic              base_wb_c;
    logic              accept_c;
    logic              base_wb_ok_c;

    mem_addr_gen u_addr_gen (
        .rn_value_i   (rn_value),
        .imm12_i      (imm12),
        .p_i          (P),
        .u_i          (U),
        .w_i          (W),
        .offset_addr_c(offset_addr_c),
        .access_addr_c(access_addr_c),
        .base_wb_c    (base_wb_c)
    );

    assign accept_c = instr_valid && cond_pass && is_mem_op(opcode);

    // Transaction context captured on accept.
    always_comb begin
        txn_d             = '0;
        txn_d.addr        = access_addr_c;
        txn_d.wdata       = rd_value;
        txn_d.rd          = rd;
        txn_d.rn          = rn;
        txn_d.offset_addr = offset_addr_c;
        txn_d.is_load     = (opcode == OPC_LDR);
        txn_d.base_wb     = base_wb_c;
    end

    // A load into its own base register keeps the loaded value.
    assign base_wb_ok_c = txn_q.base_wb && !(txn_q.is_load && (txn_q.rd == txn_q.rn));

`ifdef MEM_TIMEOUT_EN
    logic [WAIT_W-1:0] wait_cnt_q;
    logic              fault_q;
`endif

    // FSM plus all registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= ST_IDLE;
            txn_q          <= '0;
            mem_req_q      <= 1'b0;
            mem_we_q       <= 1'b0;
            stall_q        <= 1'b0;
            wb_en_q        <= 1'b0;
            wb_rd_q        <= '0;
            wb_data_q      <= '0;
            base_wb_en_q   <= 1'b0;
            base_wb_rd_q   <= '0;
            base_wb_data_q <= '0;
`ifdef MEM_TIMEOUT_EN
            wait_cnt_q     <= '0;
            fault_q        <= 1'b0;
`endif
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (accept_c) begin
                        state_q   <= ST_REQ;
                        txn_q     <= txn_d;
                        mem_req_q <= 1'b1;
                        mem_we_q  <= !txn_d.is_load;
                        stall_q   <= 1'b1;
`ifdef MEM_TIMEOUT_EN
                        wait_cnt_q <= '0;
`endif
                    end
                end
                ST_REQ: begin
                    if (bus.mem_ack) begin
                        state_q   <= ST_DONE;
                        mem_req_q <= 1'b0;
                        mem_we_q  <= 1'b0;
                        stall_q   <= 1'b0;
                        if (txn_q.is_load) begin
                            wb_en_q   <= 1'b1;
                            wb_rd_q   <= txn_q.rd;
                            wb_data_q <= bus.mem_rdata;
                        end
                        if (base_wb_ok_c) begin
                            base_wb_en_q   <= 1'b1;
                            base_wb_rd_q   <= txn_q.rn;
                            base_wb_data_q <= txn_q.offset_addr;
                        end
                    end
`ifdef MEM_TIMEOUT_EN
                    // Last permitted REQ cycle without ack: abandon, no writeback.
                    else if (wait_cnt_q == WAIT_W'(TIMEOUT_LIMIT - 1)) begin
                        state_q   <= ST_IDLE;
                        mem_req_q <= 1'b0;
                        mem_we_q  <= 1'b0;
                        stall_q   <= 1'b0;
                        fault_q   <= 1'b1;
                    end else begin
                        wait_cnt_q <= wait_cnt_q + WAIT_W'(1);
                    end
`endif
                end
                ST_DONE: begin
                    state_q      <= ST_IDLE;
                    wb_en_q      <= 1'b0;
                    base_wb_en_q <= 1'b0;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign bus.mem_req   = mem_req_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = txn_q.addr;
    assign bus.mem_wdata = txn_q.wdata;

    assign stall        = stall_q;
    assign wb_en        = wb_en_q;
    assign wb_rd        = wb_rd_q;
    assign wb_data      = wb_data_q;
    assign base_wb_en   = base_wb_en_q;
    assign base_wb_rd   = base_wb_rd_q;
    assign base_wb_data = base_wb_data_q;

`ifdef MEM_TIMEOUT_EN
    assign mem_fault = fault_q;
`else
    assign mem_fault = 1'b0;
`endif

endmodule
